scan_sequencer: RTL and testbench

Address sequencer that drives the 7-bit address of the LED-driver control ROM. It walks addresses 0–63 once per cube row update, which shifts in pixel data, latches it, and holds the output on. It advances the row index after every pass. On request it inserts one driver mode-switch/configuration pass (addresses 64–127). It sits between the cube controller (run/mode requests) and the control ROM. The row index also feeds the frame-buffer read port.

---
 rtl/scan_seq_pkg.sv | 17 +
 rtl/scan_sequencer_step_prescaler.sv | 33 +++
 rtl/scan_sequencer.sv | 153 +++++++++++++++
 tb/tb_scan_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_seq_pkg.sv
// Shared types and address map for the LED-driver control ROM sequencer.
package scan_seq_pkg;

    localparam int unsigned ADDR_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        MODE = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] SCAN_FIRST = 7'd0;
    localparam logic [ADDR_W-1:0] SCAN_LAST  = 7'd63;
    localparam logic [ADDR_W-1:0] MODE_FIRST = 7'd64;
    localparam logic [ADDR_W-1:0] MODE_LAST  = 7'd127;

endpackage : scan_seq_pkg

// File: rtl/scan_sequencer_step_prescaler.sv
// Divides clk by DIV into a one-clock step strobe, registered and aligned to count DIV-1.
module step_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic step_o
);

    localparam int unsigned    CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             step_d;

    // Strobe is precomputed from the next count so it is high exactly while cnt_q == DIV-1.
    always_comb begin
        cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        step_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            step_o <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            step_o <= step_d;
        end
    end

endmodule : step_prescaler

// File: rtl/scan_sequencer.sv
// Walks control-ROM addresses for row scan passes and on-demand mode passes.
// Optional step prescaler enabled by defining SCAN_SEQ_PRESCALE_EN.
module scan_sequencer
    import scan_seq_pkg::*;
#(
    parameter  int unsigned NUM_ROWS = 16,
    parameter  int unsigned DIV      = 4,
    localparam int unsigned ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              mode_req,
    output logic [ADDR_W-1:0] addr,
    output logic [ROW_W-1:0]  row,
    output logic              row_done,
    output logic              frame_start,
    output logic              mode_busy,
    output logic              mode_done
);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(NUM_ROWS - 1);

    if (DIV < 2 || DIV > 256) begin : g_bad_div
        $error("scan_sequencer: DIV must be within 2..256");
    end

    logic step;

`ifdef SCAN_SEQ_PRESCALE_EN
    step_prescaler #(
        .DIV (DIV)
    ) u_step_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .step_o  (step)
    );
`else
    assign step = 1'b1;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              pending_q, pending_d;
    logic              busy_q, busy_d;
    logic              row_done_q, row_done_d;
    logic              frame_start_q, frame_start_d;
    logic              mode_done_q, mode_done_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            addr_q        <= MODE_LAST;
            row_q         <= '0;
            pending_q     <= 1'b0;
            busy_q        <= 1'b0;
            row_done_q    <= 1'b0;
            frame_start_q <= 1'b0;
            mode_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            row_q         <= row_d;
            pending_q     <= pending_d;
            busy_q        <= busy_d;
            row_done_q    <= row_done_d;
            frame_start_q <= frame_start_d;
            mode_done_q   <= mode_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        row_d         = row_q;
        pending_d     = pending_q;
        busy_d        = busy_q;
        row_done_d    = 1'b0;
        frame_start_d = 1'b0;
        mode_done_d   = 1'b0;

        // Requests are latched on any clock; one outstanding request at most.
        if (mode_req && !busy_q) begin
            pending_d = 1'b1;
            busy_d    = 1'b1;
        end

        if (step) begin
            unique case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_d = MODE;
                        addr_d  = MODE_FIRST;
                    end else if (run) begin
                        state_d = SCAN;
                        addr_d  = SCAN_FIRST;
                    end
                end
                SCAN: begin
                    if (addr_q != SCAN_LAST) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end else begin
                        row_done_d = 1'b1;
                        if (row_q == ROW_MAX) begin
                            row_d         = '0;
                            frame_start_d = 1'b1;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                        // Pass boundary: a request latched on this very clock waits one more pass.
                        if (pending_q) begin
                            state_d = MODE;
                            addr_d  = MODE_FIRST;
                        end else if (!run) begin
                            state_d = IDLE;
                            addr_d  = MODE_LAST;
                        end else begin
                            addr_d = SCAN_FIRST;
                        end
                    end
                end
                MODE: begin
                    if (addr_q != MODE_LAST) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end else begin
                        pending_d   = 1'b0;
                        busy_d      = 1'b0;
                        mode_done_d = 1'b1;
                        if (run) begin
                            state_d = SCAN;
                            addr_d  = SCAN_FIRST;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    addr_d  = MODE_LAST;
                end
            endcase
        end
    end

    assign addr        = addr_q;
    assign row         = row_q;
    assign row_done    = row_done_q;
    assign frame_start = frame_start_q;
    assign mode_busy   = busy_q;
    assign mode_done   = mode_done_q;

endmodule : scan_sequencer

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer; step timing follows SCAN_SEQ_PRESCALE_EN when defined.
module tb_scan_sequencer;

    localparam int unsigned NUM_ROWS = 16;
    localparam int unsigned DIV      = 4;
`ifdef SCAN_SEQ_PRESCALE_EN
    localparam int STEP = DIV;
`else
    localparam int STEP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run;
    logic       mode_req;
    logic [6:0] addr;
    logic [3:0] row;
    logic       row_done;
    logic       frame_start;
    logic       mode_busy;
    logic       mode_done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;

    scan_sequencer #(
        .NUM_ROWS (NUM_ROWS),
        .DIV      (DIV)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .mode_req    (mode_req),
        .addr        (addr),
        .row         (row),
        .row_done    (row_done),
        .frame_start (frame_start),
        .mode_busy   (mode_busy),
        .mode_done   (mode_done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic steps(input int n);
        tick(n * STEP);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int cyc0;
        int fs_cnt;
        int fs_at;
        int fs_row;
        int rd_cnt;

        reset_n  = 1'b0;
        run      = 1'b0;
        mode_req = 1'b0;
        tick(3);
        chk("rst_addr", 32'(addr), 32'd127);
        chk("rst_row", 32'(row), 32'd0);
        chk("rst_row_done", 32'(row_done), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_mode_busy", 32'(mode_busy), 32'd0);
        chk("rst_mode_done", 32'(mode_done), 32'd0);

        // First scan pass.
        run     = 1'b1;
        reset_n = 1'b1;
        steps(1);
        cyc0 = cyc;
        chk("first_addr", 32'(addr), 32'd0);
        tick(STEP - 1);
        chk("addr_hold", 32'(addr), 32'd0);
        tick(1);
        chk("addr_step1", 32'(addr), 32'd1);
        steps(62);
        chk("pass1_addr63", 32'(addr), 32'd63);
        chk("pass1_row0", 32'(row), 32'd0);
        chk("pass1_no_done", 32'(row_done), 32'd0);
        steps(1);
        chk("pass1_wrap_addr", 32'(addr), 32'd0);
        chk("pass1_row1", 32'(row), 32'd1);
        chk("pass1_row_done", 32'(row_done), 32'd1);
        tick(1);
        chk("pass1_done_pulse", 32'(row_done), 32'd0);
        tick(STEP - 1);

        // Run through the rest of the frame and watch the wrap.
        fs_cnt = 0;
        fs_at  = -1;
        fs_row = -1;
        rd_cnt = 0;
        while (cyc < cyc0 + 1030 * STEP) begin
            tick(1);
            if (frame_start === 1'b1) begin
                fs_cnt++;
                fs_at  = cyc - cyc0;
                fs_row = int'(row);
            end
            if (row_done === 1'b1) rd_cnt++;
        end
        chk("frame_start_count", 32'(fs_cnt), 32'd1);
        chk("frame_start_time", 32'(fs_at), 32'(1024 * STEP));
        chk("frame_wrap_row", 32'(fs_row), 32'd0);
        chk("row_done_count", 32'(rd_cnt), 32'd15);
        chk("frame_addr6", 32'(addr), 32'd6);

        // Mode request mid-scan, pulsed on a non-step clock when prescaled.
        steps(4);
        chk("pre_req_addr10", 32'(addr), 32'd10);
        mode_req = 1'b1;
        tick(1);
        mode_req = 1'b0;
        chk("req_busy", 32'(mode_busy), 32'd1);
        tick(STEP - 1);
        chk("req_addr11", 32'(addr), 32'd11);
        steps(52);
        chk("req_scan_addr63", 32'(addr), 32'd63);
        steps(1);
        chk("mode_enter_addr", 32'(addr), 32'd64);
        chk("mode_enter_row", 32'(row), 32'd1);
        chk("mode_enter_row_done", 32'(row_done), 32'd1);
        steps(63);
        chk("mode_addr127", 32'(addr), 32'd127);
        chk("mode_busy_held", 32'(mode_busy), 32'd1);
        chk("mode_no_done_yet", 32'(mode_done), 32'd0);
        steps(1);
        chk("mode_exit_addr", 32'(addr), 32'd0);
        chk("mode_exit_row", 32'(row), 32'd1);
        chk("mode_done_pulse", 32'(mode_done), 32'd1);
        chk("mode_busy_drop", 32'(mode_busy), 32'd0);

        // Drop run mid-pass: pass completes, then park at 127.
        steps(20);
        run = 1'b0;
        steps(43);
        chk("park_addr63", 32'(addr), 32'd63);
        steps(1);
        chk("park_addr127", 32'(addr), 32'd127);
        chk("park_row2", 32'(row), 32'd2);
        chk("park_row_done", 32'(row_done), 32'd1);
        steps(5);
        chk("park_hold", 32'(addr), 32'd127);

        // Mode request while idle; a second request during MODE is dropped.
        tick(STEP - 1);
        mode_req = 1'b1;
        tick(1);
        mode_req = 1'b0;
        chk("idle_req_busy", 32'(mode_busy), 32'd1);
        chk("idle_req_addr", 32'(addr), 32'd127);
        steps(1);
        chk("idle_mode_addr64", 32'(addr), 32'd64);
        steps(10);
        mode_req = 1'b1;
        tick(1);
        mode_req = 1'b0;
        tick(STEP - 1);
        chk("idle_mode_addr75", 32'(addr), 32'd75);
        steps(52);
        chk("idle_mode_addr127", 32'(addr), 32'd127);
        steps(1);
        chk("idle_mode_done", 32'(mode_done), 32'd1);
        chk("idle_mode_park", 32'(addr), 32'd127);
        tick(1);
        chk("second_req_busy", 32'(mode_busy), 32'd0);
        chk("idle_done_pulse", 32'(mode_done), 32'd0);
        tick(STEP - 1);
        steps(3);
        chk("second_req_no_pass", 32'(addr), 32'd127);

        // Request on the same clock as the 63 step: MODE waits a full pass.
        run = 1'b1;
        steps(1);
        chk("resume_addr0", 32'(addr), 32'd0);
        chk("resume_row2", 32'(row), 32'd2);
        steps(63);
        tick(STEP - 1);
        mode_req = 1'b1;
        tick(1);
        mode_req = 1'b0;
        chk("edge_req_addr0", 32'(addr), 32'd0);
        chk("edge_req_busy", 32'(mode_busy), 32'd1);
        chk("edge_req_row3", 32'(row), 32'd3);
        steps(64);
        chk("edge_req_mode64", 32'(addr), 32'd64);
        chk("edge_req_row4", 32'(row), 32'd4);

        // Reset in the middle of a mode pass.
        steps(40);
        chk("mid_mode_addr104", 32'(addr), 32'd104);
        reset_n = 1'b0;
        tick(1);
        chk("mid_rst_addr", 32'(addr), 32'd127);
        chk("mid_rst_row", 32'(row), 32'd0);
        chk("mid_rst_busy", 32'(mode_busy), 32'd0);
        chk("mid_rst_done", 32'(mode_done), 32'd0);
        reset_n = 1'b1;
        steps(1);
        chk("post_rst_addr0", 32'(addr), 32'd0);
        chk("post_rst_no_done", 32'(mode_done), 32'd0);
        chk("post_rst_busy", 32'(mode_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_scan_sequencer
